// File: rtl/gpu_pixel_queue.sv
// gpu_pixel_queue
//   Elastic pixel queue between the rasterizer and gpu_memcontroller. Buffers
//   (x, y, r, g, b) pixel writes and presents them one word per cycle on
//   data_ready_o. A frame-done request drains all accepted pixels, then a
//   one-cycle flush_o pulse swaps the frame buffer.
//
// Ports
//   clk, n_rst                 clock, synchronous active-low reset
//   pixel_valid_i/ready_o      rasterizer handshake (transfer on valid && ready)
//   r_i, g_i, b_i, x_i, y_i    pixel colour and coordinates
//   frame_done_i               single-cycle end-of-frame request (RUN only)
//   mem_hold_i                 stalls draining while high
//   data_ready_o, *data_o      one-cycle word strobe and registered pixel data
//   adddatax_o, adddatay_o     registered pixel address
//   flush_o                    one-cycle frame-buffer swap pulse
//   count_o                    occupancy, 0..DEPTH
//   busy_o                     high while not accepting a frame (DRAIN/SWAP)
//
// CHANNEL_BITS/WIDTH_BITS/HEIGHT_BITS must match the values used by the memory
// controller (gpu_definitions.vh).
module gpu_pixel_queue #(
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned CHANNEL_BITS = 8,
    parameter int unsigned WIDTH_BITS   = 10,
    parameter int unsigned HEIGHT_BITS  = 9
) (
    input  logic                      clk,
    input  logic                      n_rst,
    input  logic                      pixel_valid_i,
    output logic                      pixel_ready_o,
    input  logic [CHANNEL_BITS-1:0]   r_i,
    input  logic [CHANNEL_BITS-1:0]   g_i,
    input  logic [CHANNEL_BITS-1:0]   b_i,
    input  logic [WIDTH_BITS-1:0]     x_i,
    input  logic [HEIGHT_BITS-1:0]    y_i,
    input  logic                      frame_done_i,
    input  logic                      mem_hold_i,
    output logic                      data_ready_o,
    output logic [CHANNEL_BITS-1:0]   rdata_o,
    output logic [CHANNEL_BITS-1:0]   gdata_o,
    output logic [CHANNEL_BITS-1:0]   bdata_o,
    output logic [WIDTH_BITS-1:0]     adddatax_o,
    output logic [HEIGHT_BITS-1:0]    adddatay_o,
    output logic                      flush_o,
    output logic [$clog2(DEPTH):0]    count_o,
    output logic                      busy_o
);

    localparam int unsigned PTR_BITS   = $clog2(DEPTH);
    localparam int unsigned CNT_BITS   = PTR_BITS + 1;
    localparam int unsigned ENTRY_BITS = 3 * CHANNEL_BITS + WIDTH_BITS + HEIGHT_BITS;
    localparam logic [CNT_BITS-1:0] FULL_COUNT = CNT_BITS'(DEPTH);

    typedef enum logic [1:0] {StRun, StDrain, StSwap} state_e;

    state_e                  state_q;
    logic [PTR_BITS-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CNT_BITS-1:0]     count_q, count_d;
    logic [ENTRY_BITS-1:0]   mem_q [DEPTH];
    logic                    data_ready_q;
    logic [CHANNEL_BITS-1:0] rdata_q, gdata_q, bdata_q;
    logic [WIDTH_BITS-1:0]   x_q;
    logic [HEIGHT_BITS-1:0]  y_q;
    logic                    push, pop;

    assign pixel_ready_o = (state_q == StRun) && (count_q != FULL_COUNT);
    assign push          = pixel_valid_i && pixel_ready_o;
    // Popping ignores state so DRAIN keeps emptying the queue.
    assign pop           = (count_q != '0) && !mem_hold_i;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_BITS'(1);
        end else if (!push && pop) begin
            count_d = count_q - CNT_BITS'(1);
        end
    end

    // Storage is not reset: entries are only read once the counter says valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {r_i, g_i, b_i, x_i, y_i};
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q      <= StRun;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            data_ready_q <= 1'b0;
            rdata_q      <= '0;
            gdata_q      <= '0;
            bdata_q      <= '0;
            x_q          <= '0;
            y_q          <= '0;
        end else begin
            count_q      <= count_d;
            data_ready_q <= pop;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_BITS'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_BITS'(1);
                {rdata_q, gdata_q, bdata_q, x_q, y_q} <= mem_q[rd_ptr_q];
            end
            unique case (state_q)
                StRun: begin
                    if (frame_done_i) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    // Wait until the final word has also left the output register.
                    if ((count_q == '0) && !data_ready_q) begin
                        state_q <= StSwap;
                    end
                end
                StSwap:  state_q <= StRun;
                default: state_q <= StRun;
            endcase
        end
    end

    assign data_ready_o = data_ready_q;
    assign rdata_o      = rdata_q;
    assign gdata_o      = gdata_q;
    assign bdata_o      = bdata_q;
    assign adddatax_o   = x_q;
    assign adddatay_o   = y_q;
    assign flush_o      = (state_q == StSwap);
    assign count_o      = count_q;
    assign busy_o       = (state_q != StRun);

endmodule

// File: tb/tb_gpu_pixel_queue.sv
// Self-checking bench for gpu_pixel_queue: directed stimulus pushes expected
// words into a scoreboard queue; a monitor pops and compares on data_ready_o.
module tb_gpu_pixel_queue;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        pixel_valid_i;
    logic        pixel_ready_o;
    logic [7:0]  r_i, g_i, b_i;
    logic [9:0]  x_i;
    logic [8:0]  y_i;
    logic        frame_done_i;
    logic        mem_hold_i;
    logic        data_ready_o;
    logic [7:0]  rdata_o, gdata_o, bdata_o;
    logic [9:0]  adddatax_o;
    logic [8:0]  adddatay_o;
    logic        flush_o;
    logic [4:0]  count_o;
    logic        busy_o;

    gpu_pixel_queue #(
        .DEPTH(16), .CHANNEL_BITS(8), .WIDTH_BITS(10), .HEIGHT_BITS(9)
    ) dut (
        .clk(clk), .n_rst(n_rst),
        .pixel_valid_i(pixel_valid_i), .pixel_ready_o(pixel_ready_o),
        .r_i(r_i), .g_i(g_i), .b_i(b_i), .x_i(x_i), .y_i(y_i),
        .frame_done_i(frame_done_i), .mem_hold_i(mem_hold_i),
        .data_ready_o(data_ready_o),
        .rdata_o(rdata_o), .gdata_o(gdata_o), .bdata_o(bdata_o),
        .adddatax_o(adddatax_o), .adddatay_o(adddatay_o),
        .flush_o(flush_o), .count_o(count_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int flush_cnt = 0;
    logic [42:0] sb [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [42:0] pix(input int i);
        return {8'(i), 8'(i + 1), 8'(i + 2), 10'(i * 3), 9'(i * 2)};
    endfunction

    task automatic drive(input logic [42:0] p);
        {r_i, g_i, b_i, x_i, y_i} = p;
        pixel_valid_i = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every presented word must be the oldest expected one.
    always @(negedge clk) begin
        if (n_rst) begin
            if (data_ready_o) begin
                if (sb.size() == 0) begin
                    check("unexpected_word", {21'd0, rdata_o, gdata_o, bdata_o, adddatax_o,
                          adddatay_o}, 64'h0);
                    checks++;
                    $display("FAIL unexpected_word: data_ready_o high, scoreboard empty");
                end else begin
                    check("word", {21'd0, rdata_o, gdata_o, bdata_o, adddatax_o, adddatay_o},
                          {21'd0, sb.pop_front()});
                end
            end
            if (flush_o) begin
                flush_cnt++;
                check("flush_vs_data_ready", 64'(data_ready_o), 64'd0);
            end
        end
    end

    localparam logic [7:0] FR_DR  = 8'b0001_1111;  // bit s: expected data_ready_o at step s
    localparam logic [7:0] FR_FL  = 8'b0100_0000;
    localparam logic [7:0] FR_RDY = 8'b1000_0000;

    initial begin
        logic [7:0] fr_dr, fr_fl, fr_rdy;
        fr_dr = FR_DR; fr_fl = FR_FL; fr_rdy = FR_RDY;
        n_rst = 1'b0;
        frame_done_i = 1'b0;
        mem_hold_i = 1'b0;
        drive(pix(7));  // traffic during reset must be ignored

        // Reset
        step(); step();
        check("rst_count", 64'(count_o), 64'd0);
        check("rst_data_ready", 64'(data_ready_o), 64'd0);
        check("rst_flush", 64'(flush_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_outputs", {21'd0, rdata_o, gdata_o, bdata_o, adddatax_o, adddatay_o}, 64'd0);
        pixel_valid_i = 1'b0;
        n_rst = 1'b1;
        check("rst_ready", 64'(pixel_ready_o), 64'd1);

        // Single pixel: accepted at N, presented N+1..N+2 only
        drive({8'd1, 8'd2, 8'd3, 10'd5, 9'd3});
        sb.push_back({8'd1, 8'd2, 8'd3, 10'd5, 9'd3});
        step();
        pixel_valid_i = 1'b0;
        check("single_count", 64'(count_o), 64'd1);
        check("single_dr_before", 64'(data_ready_o), 64'd0);
        step();
        check("single_dr", 64'(data_ready_o), 64'd1);
        step();
        check("single_dr_after", 64'(data_ready_o), 64'd0);

        // Fill under hold, then drain in order on consecutive cycles
        mem_hold_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            drive(pix(10 + i));
            sb.push_back(pix(10 + i));
            step();
        end
        pixel_valid_i = 1'b0;
        check("fill_count", 64'(count_o), 64'd16);
        check("fill_ready", 64'(pixel_ready_o), 64'd0);
        drive(pix(99));  // must not be accepted
        step();
        pixel_valid_i = 1'b0;
        check("full_count", 64'(count_o), 64'd16);
        check("full_no_dr", 64'(data_ready_o), 64'd0);
        mem_hold_i = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step();
            check("fill_drain_dr", 64'(data_ready_o), 64'd1);
        end
        step();
        check("fill_drain_end_dr", 64'(data_ready_o), 64'd0);
        check("fill_drain_end_count", 64'(count_o), 64'd0);

        // Streaming: one push per cycle, occupancy never exceeds 1
        for (int i = 0; i < 100; i++) begin
            drive(pix(40 + i));
            sb.push_back(pix(40 + i));
            step();
            check("stream_count", 64'(count_o <= 5'd1), 64'd1);
            if (i > 0) check("stream_dr", 64'(data_ready_o), 64'd1);
        end
        pixel_valid_i = 1'b0;
        step();
        check("stream_last_dr", 64'(data_ready_o), 64'd1);
        check("stream_end_count", 64'(count_o), 64'd0);
        step();
        check("stream_idle_dr", 64'(data_ready_o), 64'd0);

        // Frame end: 4 queued under hold, frame_done with 5th push and hold released
        mem_hold_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(pix(200 + i));
            sb.push_back(pix(200 + i));
            step();
        end
        drive(pix(204));
        sb.push_back(pix(204));
        frame_done_i = 1'b1;
        mem_hold_i = 1'b0;
        step();  // edge F
        pixel_valid_i = 1'b0;
        frame_done_i = 1'b0;
        check("frame_count_after_F", 64'(count_o), 64'd4);
        // Words pop at F..F+4; at F+5 output register empties; SWAP entered at F+6.
        for (int s = 0; s < 8; s++) begin
            check("frame_dr", 64'(data_ready_o), 64'(fr_dr[s]));
            check("frame_flush", 64'(flush_o), 64'(fr_fl[s]));
            check("frame_ready", 64'(pixel_ready_o), 64'(fr_rdy[s]));
            check("frame_busy", 64'(busy_o), 64'(!fr_rdy[s]));
            frame_done_i = (s == 2);  // request during DRAIN is ignored
            step();
        end
        frame_done_i = 1'b0;
        repeat (4) step();
        check("frame_single_flush", 64'(flush_cnt), 64'd1);

        // frame_done at an empty idle queue: SWAP at F+1, RUN at F+2
        frame_done_i = 1'b1;
        step();
        frame_done_i = 1'b0;
        check("empty_busy", 64'(busy_o), 64'd1);
        check("empty_flush0", 64'(flush_o), 64'd0);
        step();
        check("empty_flush1", 64'(flush_o), 64'd1);
        step();
        check("empty_flush_end", 64'(flush_o), 64'd0);
        check("empty_ready", 64'(pixel_ready_o), 64'd1);
        check("empty_flush_cnt", 64'(flush_cnt), 64'd2);

        // Reset in the middle of DRAIN with 6 queued
        mem_hold_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(pix(300 + i));
            step();
        end
        pixel_valid_i = 1'b0;
        frame_done_i = 1'b1;
        step();
        frame_done_i = 1'b0;
        check("mid_count", 64'(count_o), 64'd6);
        check("mid_busy", 64'(busy_o), 64'd1);
        n_rst = 1'b0;
        step();
        n_rst = 1'b1;
        mem_hold_i = 1'b0;
        check("mid_rst_count", 64'(count_o), 64'd0);
        check("mid_rst_busy", 64'(busy_o), 64'd0);
        check("mid_rst_ready", 64'(pixel_ready_o), 64'd1);
        repeat (6) begin
            step();
            check("mid_rst_no_dr", 64'(data_ready_o), 64'd0);
        end
        check("mid_rst_no_flush", 64'(flush_cnt), 64'd2);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/gpu_pixel_queue.md
# gpu_pixel_queue

Elastic pixel queue between the rasterizer and `gpu_memcontroller`. It buffers (x, y, r, g, b) pixel writes from the rasterizer and presents them to the memory controller one pixel per cycle on `data_ready`. It also sequences frame completion: a frame-done request drains all accepted pixels before a one-cycle `flush` pulse swaps the frame buffer.

## Interface

Parameters
- `DEPTH`, default 16: queue entries; must be a power of two, ≥ 2.
- Channel and coordinate widths come from `gpu_definitions.vh`: `CHANNEL_BITS`, `WIDTH_BITS`, `HEIGHT_BITS`.

Ports (clock and reset first)
- `clk`  in  1  — system clock; all state changes on its rising edge.
- `n_rst`  in  1  — synchronous, active-low reset, sampled on the rising edge of `clk`.
- `pixel_valid_i`  in  1  — rasterizer offers a pixel.
- `pixel_ready_o`  out  1  — queue accepts; a transfer occurs on an edge where valid && ready.
- `r_i`, `g_i`, `b_i`  in  `CHANNEL_BITS` each  — pixel colour.
- `x_i`  in  `WIDTH_BITS`  — pixel column.
- `y_i`  in  `HEIGHT_BITS`  — pixel row.
- `frame_done_i`  in  1  — single-cycle request to end the current frame.
- `mem_hold_i`  in  1  — stalls draining; no new word is presented while high.
- `data_ready_o`  out  1  — drives memcontroller `data_ready_i`.
- `rdata_o`, `gdata_o`, `bdata_o`  out  `CHANNEL_BITS` each  — drive `rdata`, `gdata`, `bdata`.
- `adddatax_o`  out  `WIDTH_BITS`; `adddatay_o`  out  `HEIGHT_BITS`  — drive `adddatax`, `adddatay`.
- `flush_o`  out  1  — drives memcontroller `flush`; exactly one cycle per frame.
- `count_o`  out  $clog2(DEPTH)+1  — current occupancy, 0..DEPTH.
- `busy_o`  out  1  — high whenever state ≠ RUN.

## Operation

- Storage: circular buffer of `DEPTH` entries, packed {r, g, b, x, y}. Read and write pointers are $clog2(DEPTH) bits and wrap naturally. Occupancy is tracked in a separate counter.
- `pixel_ready_o` = (state == RUN) && (count < DEPTH). It is purely combinational from registered state.
- Push: on an edge with valid && ready, write the entry at the write pointer and increment the write pointer.
- Pop: on an edge with count > 0 && !mem_hold_i, load the head entry into the output registers, set `data_ready_o` = 1, and increment the read pointer.
- On any other edge, `data_ready_o` = 0 and the data and address outputs hold their last values. Each word is therefore presented for exactly one cycle.
- Pop is independent of state; draining continues in DRAIN.
- Simultaneous push and pop: both occur and count is unchanged. When count == DEPTH no push occurs, even if a pop happens on the same edge.
- FSM states:
  - RUN → DRAIN on an edge with `frame_done_i` = 1. A pixel accepted on that same edge belongs to the ending frame.
  - DRAIN → SWAP when count == 0 and `data_ready_o` == 0, i.e. the last word has already been presented and captured.
  - SWAP → RUN unconditionally after one cycle.
- `flush_o` = (state == SWAP). Because it is Moore and one cycle long, it never coincides with `data_ready_o` = 1.
- `frame_done_i` is ignored outside RUN.
- Reset (synchronous, also mid-frame): state = RUN, pointers = 0, count = 0, `data_ready_o` = 0, `flush_o` = 0, colour/address outputs = 0, `busy_o` = 0. Queued pixels are discarded and no flush is issued. `pixel_ready_o` = 1 from the first cycle after reset.

## Timing

- Latency: pixel accepted at edge N into an empty queue with `mem_hold_i` low → popped at edge N+1 → `data_ready_o` high during cycle N+1..N+2.
- Throughput: 1 pixel/cycle sustained with concurrent push/pop.
- `mem_hold_i` rising before edge E: no pop at E, so `data_ready_o` = 0 after E. Release resumes popping at the next edge.
- Frame end: `frame_done_i` at edge F with queue count K and no hold:
  - `data_ready_o` high for K consecutive cycles after F.
  - DRAIN→SWAP occurs at the edge where count == 0 and `data_ready_o` == 0.
  - `flush_o` high for the following cycle, then `pixel_ready_o` returns high.
- `frame_done_i` at an empty, idle queue: SWAP at F+1, `flush_o` during F+1..F+2, RUN at F+2.

## Test plan

- Reset: hold `n_rst` low for 2 edges with valid traffic applied → count_o = 0, data_ready_o = 0, flush_o = 0, all outputs 0. pixel_ready_o = 1 once `n_rst` is released.
- Single pixel: push (x = 5, y = 3, r = 1, g = 2, b = 3) at edge N → data_ready_o = 1 with exactly those values for one cycle after N+1, then 0.
- Fill and backpressure: `mem_hold_i` = 1, push 16 pixels → count_o = 16, pixel_ready_o = 0. A 17th valid is not accepted. Release hold → 16 words out in push order on consecutive cycles, then count_o = 0.
- Streaming: push every cycle for 100 cycles without hold → count_o stays ≤ 1. 100 data_ready_o pulses in order, no gaps after the first word.
- Frame end: queue 4 pixels, assert frame_done_i together with a 5th push → 5 words out. flush_o is a single-cycle pulse in the cycle after the last word. pixel_ready_o = 0 from DRAIN through SWAP. A frame_done_i issued during DRAIN produces no second flush.
- Reset mid-DRAIN with count_o = 6 → flush_o never pulses, count_o = 0, state RUN on the next cycle.
